sram_dma: RTL and testbench
===========================

Name: sram_dma

Overview:
- Byte-wide block-copy/fill engine; bus initiator on the CPU-side port of the SRAM controller (address, write data, read data, rw, cs).
- CPU programs it through an 8-register peripheral window, then grants it the bus with a req/gnt handshake.
- Moves one byte per 2 clocks (RD then WR) in copy mode, one byte per clock in fill mode.
- SRAM page select is held at 0 by system wiring during DMA; the engine sees the flat 64 KiB space.

Parameters:
- LEN_W, 16, width of the length counter; bytes per transfer ≤ 2^LEN_W-1.

Ports:
- clk  in  1  system clock; SRAM controller strobes OE/WE in the low phase.
- rst_n  in  1  asynchronous active-low reset.
- reg_cs  in  1  register window select.
- reg_rw  in  1  1 = read, 0 = write.
- reg_ad  in  3  register index.
- reg_di  in  8  register write data.
- reg_do  out  8  register read data, combinational.
- dma_req  out  1  bus request to CPU/arbiter.
- dma_gnt  in  1  bus granted; CPU tristates/halts while high.
- mem_ad  out  16  SRAM address.
- mem_do  out  8  SRAM write data.
- mem_di  in  8  SRAM read data.
- mem_rw  out  1  1 = read, 0 = write.
- mem_cs  out  1  SRAM select.
- irq  out  1  completion interrupt (tied 0 without DMA_IRQ_EN).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - All registers 0; state IDLE; done=0; abort flag=0.
  - dma_req=0, mem_cs=0, mem_rw=1, mem_ad=0, mem_do=0, irq=0.
- Registers (write on rising clk when reg_cs & !reg_rw):
  - 0 SRC_H, 1 SRC_L, 2 DST_H, 3 DST_L, 4 LEN_H, 5 LEN_L.
  - 6 CTRL/STATUS. Write: bit0 START, bit1 FILL, bit2 ABORT, bit7 IE. Read: bit7 BUSY, bit6 DONE, bit5 ABORTED, bit1 FILL, bit0 0.
  - 7 FILL value.
- Writes to regs 0-5 and 7 while BUSY are ignored. A CTRL write while BUSY honours ABORT only.
- SRC/DST/LEN update live and are readable as progress.
- States: IDLE, REQ, RD, WR.
  - IDLE: START with LEN≠0 → REQ, BUSY=1, DONE=0, ABORTED=0. START with LEN=0 → DONE=1, no bus cycles, stays IDLE.
  - REQ: dma_req=1; gnt=1 → RD (copy) or WR (fill).
  - RD: mem_ad=SRC, mem_rw=1, mem_cs=gnt. On the edge with gnt=1: latch mem_di into the data buffer, SRC+1 → WR.
  - WR: mem_ad=DST, mem_rw=0, mem_do = buffer (copy) or FILL, mem_cs=gnt. On the edge with gnt=1: DST+1, LEN-1.
    - New LEN=0 → IDLE, DONE=1, dma_req=0.
    - Else → RD (copy) or stays WR (fill).
- dma_req stays 1 from REQ until return to IDLE.
- gnt low in RD/WR: cs=0, state and counters hold, cycle retried when gnt returns.
- Address wrap: 0xFFFF+1 = 0x0000, no error.
- ABORT: next edge → IDLE, dma_req=0, ABORTED=1, DONE=0. A bus cycle completing on that same edge still takes effect.
- START while BUSY is ignored.
- Reset mid-transfer drops dma_req/mem_cs asynchronously.

Optional Feature:
- Macro: DMA_IRQ_EN.
- Defined:
  - irq = DONE & IE, level-held.
  - Cleared by reading reg 6 (read clears DONE) or by a new START.
- Undefined:
  - irq tied 0; IE bit reads 0.
  - DONE cleared only by START.

Test Plan:
- Copy: SRC=0x1000, DST=0x2000, LEN=3, START, gnt tied 1 → dma_req high within 1 clk; 6 bus cycles alternating rw=1/0; [0x2000..2] = [0x1000..2]; DONE=1, SRC=0x1003, DST=0x2003, LEN=0.
- Fill: FILL=0xA5, DST=0x3000, LEN=4, ctrl=0x03 → exactly 4 consecutive write cycles of 0xA5 at 0x3000-0x3003, no read cycles.
- LEN=0 START → DONE=1 next clock, dma_req never asserted.
- Grant stall: LEN=2 copy, drop gnt for 3 clocks during first WR → mem_cs=0 those clocks; data correct; total 4 completed bus cycles.
- Abort/wrap: SRC=0xFFFF, LEN=5, write ABORT after 3 cycles → dma_req=0 next clock; ABORTED=1, DONE=0; SRC shows the wrapped value 0x0000 or 0x0001.
- DMA_IRQ_EN: IE=1, LEN=1 copy → irq rises with DONE; status read → irq and DONE clear next clock.

Source files
------------

// File: rtl/sram_dma_if.sv
// SRAM CPU-side bus plus DMA request/grant handshake shared by the DMA engine
// (master) and the SRAM controller / bus arbiter (slave).
interface sram_dma_if;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] mem_ad;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di;
  logic        mem_rw;
  logic        mem_cs;

  modport master (
    output dma_req, mem_ad, mem_do, mem_rw, mem_cs,
    input  dma_gnt, mem_di
  );

  modport slave (
    input  dma_req, mem_ad, mem_do, mem_rw, mem_cs,
    output dma_gnt, mem_di
  );
endinterface

// File: rtl/sram_dma.sv
// Byte-wide block copy/fill DMA engine on the SRAM CPU-side port.
// Optional macro DMA_IRQ_EN adds the level completion interrupt and read-to-clear DONE.
module sram_dma #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_cs_i,
  input  logic        reg_rw_i,
  input  logic [2:0]  reg_ad_i,
  input  logic [7:0]  reg_di_i,
  output logic [7:0]  reg_do_o,
  output logic        irq_o,
  sram_dma_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RD, WR} state_e;

  state_e           state_q, state_d;
  logic [15:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       fill_val_q, fill_val_d, buf_q, buf_d;
  logic             fill_mode_q, fill_mode_d;
  logic             done_q, done_d, aborted_q, aborted_d;
  logic             ie_q, ie_d;
  logic             busy, reg_wr;
  logic [15:0]      len_ext;

  assign busy    = (state_q != IDLE);
  assign reg_wr  = reg_cs_i & ~reg_rw_i;
  assign len_ext = 16'(len_q);

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    fill_val_d  = fill_val_q;
    buf_d       = buf_q;
    fill_mode_d = fill_mode_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    ie_d        = ie_q;

`ifdef DMA_IRQ_EN
    // Status read acknowledges completion; a same-edge completion below still wins.
    if (reg_cs_i && reg_rw_i && reg_ad_i == 3'd6) done_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (reg_wr) begin
          case (reg_ad_i)
            3'd0: src_d[15:8] = reg_di_i;
            3'd1: src_d[7:0]  = reg_di_i;
            3'd2: dst_d[15:8] = reg_di_i;
            3'd3: dst_d[7:0]  = reg_di_i;
            3'd4: len_d = LEN_W'({reg_di_i, len_ext[7:0]});
            3'd5: len_d = LEN_W'({len_ext[15:8], reg_di_i});
            3'd6: begin
              fill_mode_d = reg_di_i[1];
`ifdef DMA_IRQ_EN
              ie_d        = reg_di_i[7];
`endif
              if (reg_di_i[0]) begin
                aborted_d = 1'b0;
                if (len_q != '0) begin
                  state_d = REQ;
                  done_d  = 1'b0;
                end else begin
                  done_d  = 1'b1;
                end
              end
            end
            default: fill_val_d = reg_di_i;
          endcase
        end
      end
      REQ: if (bus.dma_gnt) state_d = fill_mode_q ? WR : RD;
      RD: begin
        if (bus.dma_gnt) begin
          buf_d   = bus.mem_di;
          src_d   = src_q + 16'd1;
          state_d = WR;
        end
      end
      WR: begin
        if (bus.dma_gnt) begin
          dst_d = dst_q + 16'd1;
          len_d = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (!fill_mode_q) begin
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides the state move but keeps the effects of a bus cycle finishing on this edge.
    if (busy && reg_wr && reg_ad_i == 3'd6 && reg_di_i[2]) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
      done_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      fill_val_q  <= '0;
      buf_q       <= '0;
      fill_mode_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      ie_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      fill_val_q  <= fill_val_d;
      buf_q       <= buf_d;
      fill_mode_q <= fill_mode_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      ie_q        <= ie_d;
    end
  end

  // Bus outputs decode straight from state so reset drops cs/req without waiting for a clock.
  always_comb begin
    bus.mem_ad = '0;
    bus.mem_do = '0;
    bus.mem_rw = 1'b1;
    bus.mem_cs = 1'b0;
    case (state_q)
      RD: begin
        bus.mem_ad = src_q;
        bus.mem_cs = bus.dma_gnt;
      end
      WR: begin
        bus.mem_ad = dst_q;
        bus.mem_rw = 1'b0;
        bus.mem_do = fill_mode_q ? fill_val_q : buf_q;
        bus.mem_cs = bus.dma_gnt;
      end
      default: ;
    endcase
  end

  assign bus.dma_req = busy;

  always_comb begin
    case (reg_ad_i)
      3'd0:    reg_do_o = src_q[15:8];
      3'd1:    reg_do_o = src_q[7:0];
      3'd2:    reg_do_o = dst_q[15:8];
      3'd3:    reg_do_o = dst_q[7:0];
      3'd4:    reg_do_o = len_ext[15:8];
      3'd5:    reg_do_o = len_ext[7:0];
      3'd6:    reg_do_o = {busy, done_q, aborted_q, 3'b000, fill_mode_q, 1'b0};
      default: reg_do_o = fill_val_q;
    endcase
  end

`ifdef DMA_IRQ_EN
  assign irq_o = done_q & ie_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_dma.sv
// Randomized self-checking bench for sram_dma against a byte-level memory model.
module tb_sram_dma;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_cs, reg_rw;
  logic [2:0] reg_ad;
  logic [7:0] reg_di, reg_do;
  logic       irq;
  logic       gnt_force, rand_gnt, gnt_rnd;

  int n_checks = 0;
  int n_errors = 0;
  int n_rd, n_wr, n_busy;

  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  sram_dma_if bus ();

  assign bus.dma_gnt = rand_gnt ? gnt_rnd : gnt_force;
  assign bus.mem_di  = sram[bus.mem_ad];

  sram_dma #(.LEN_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_cs_i (reg_cs),
    .reg_rw_i (reg_rw),
    .reg_ad_i (reg_ad),
    .reg_di_i (reg_di),
    .reg_do_o (reg_do),
    .irq_o    (irq),
    .bus      (bus)
  );

  // SRAM model and bus-cycle counters: a cycle completes on an edge with cs high.
  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = 8'($urandom);
    n_rd = 0; n_wr = 0; n_busy = 0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (bus.dma_req) n_busy <= n_busy + 1;
        if (bus.mem_cs && bus.dma_gnt) begin
          if (bus.mem_rw) n_rd <= n_rd + 1;
          else begin
            n_wr <= n_wr + 1;
            sram[bus.mem_ad] <= bus.mem_do;
          end
        end
      end
    end
  end

  initial begin
    gnt_rnd = 1'b1;
    forever begin
      @(negedge clk);
      gnt_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register access tasks are entered at a negedge and return at the next negedge.
  task automatic reg_write(input logic [2:0] ad, input logic [7:0] d);
    reg_cs = 1'b1; reg_rw = 1'b0; reg_ad = ad; reg_di = d;
    @(negedge clk);
    reg_cs = 1'b0; reg_rw = 1'b1;
  endtask

  task automatic reg_read(input logic [2:0] ad, output logic [7:0] d);
    reg_cs = 1'b1; reg_rw = 1'b1; reg_ad = ad;
    #1 d = reg_do;
    @(negedge clk);
    reg_cs = 1'b0;
  endtask

  task automatic peek(input logic [2:0] ad, output logic [7:0] d);
    reg_ad = ad;
    #1 d = reg_do;
  endtask

  task automatic prog_regs(input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input logic [7:0] fv);
    reg_write(3'd0, src[15:8]); reg_write(3'd1, src[7:0]);
    reg_write(3'd2, dst[15:8]); reg_write(3'd3, dst[7:0]);
    reg_write(3'd4, len[15:8]); reg_write(3'd5, len[7:0]);
    reg_write(3'd7, fv);
  endtask

  // Reference: byte i of the block is written in order, reading the source after earlier writes.
  task automatic model_apply(input logic [15:0] src, input logic [15:0] dst, input int n,
                             input bit fill, input logic [7:0] fv);
    for (int i = 0; i < n; i++) begin
      ref_mem[16'(dst + 16'(i))] = fill ? fv : ref_mem[16'(src + 16'(i))];
    end
  endtask

  task automatic mem_compare(input string tag);
    int diffs = 0;
    for (int i = 0; i < 65536; i++) if (sram[i] !== ref_mem[i]) diffs++;
    check({tag, " mem diffs"}, diffs, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (bus.dma_req && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, " finished"}, bus.dma_req, 0);
  endtask

  task automatic check_regs(input string tag, input logic [15:0] es, input logic [15:0] ed,
                            input logic [15:0] el, input logic [7:0] est);
    logic [7:0] h, l;
    reg_read(3'd0, h); reg_read(3'd1, l); check({tag, " src"}, {h, l}, es);
    reg_read(3'd2, h); reg_read(3'd3, l); check({tag, " dst"}, {h, l}, ed);
    reg_read(3'd4, h); reg_read(3'd5, l); check({tag, " len"}, {h, l}, el);
    reg_read(3'd6, h); check({tag, " status"}, h, est);
  endtask

  task automatic run_xfer(input string tag, input logic [15:0] src, input logic [15:0] dst,
                          input int len, input bit fill, input logic [7:0] fv, input bit rnd);
    int b_rd, b_wr, b_busy;
    logic [15:0] es;
    rand_gnt = rnd; gnt_force = 1'b1;
    prog_regs(src, dst, 16'(len), fv);
    model_apply(src, dst, len, fill, fv);
    b_rd = n_rd; b_wr = n_wr; b_busy = n_busy;
    reg_write(3'd6, {1'b1, 5'b0, fill, 1'b1});
    check({tag, " req"}, bus.dma_req, 1);
    wait_idle(tag, 40 * len + 20);
    check({tag, " reads"}, n_rd - b_rd, fill ? 0 : len);
    check({tag, " writes"}, n_wr - b_wr, len);
    if (!rnd) check({tag, " busy clocks"}, n_busy - b_busy, fill ? len + 1 : 2 * len + 1);
`ifdef DMA_IRQ_EN
    check({tag, " irq"}, irq, 1);
`else
    check({tag, " irq"}, irq, 0);
`endif
    es = fill ? src : 16'(src + 16'(len));
    check_regs(tag, es, 16'(dst + 16'(len)), 16'h0000, {6'b010000, fill, 1'b0});
    mem_compare(tag);
    rand_gnt = 1'b0;
  endtask

  initial begin : main
    logic [7:0] d;
    int base, k;
    rst_n = 1'b0; reg_cs = 1'b0; reg_rw = 1'b1; reg_ad = '0; reg_di = '0;
    gnt_force = 1'b0; rand_gnt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst dma_req", bus.dma_req, 0);
    check("rst mem_cs", bus.mem_cs, 0);
    check("rst mem_rw", bus.mem_rw, 1);
    check("rst mem_ad", bus.mem_ad, 0);
    check("rst mem_do", bus.mem_do, 0);
    check("rst irq", irq, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) ref_mem[i] = sram[i];
    for (int r = 0; r < 8; r++) begin
      reg_read(3'(r), d);
      check($sformatf("rst reg%0d", r), d, 0);
    end

    run_xfer("copy", 16'h1000, 16'h2000, 3, 1'b0, 8'h00, 1'b0);
    run_xfer("fill", 16'h0000, 16'h3000, 4, 1'b1, 8'hA5, 1'b0);

    // Zero-length start completes at once without touching the bus.
    gnt_force = 1'b1;
    prog_regs(16'h0100, 16'h0200, 16'h0000, 8'h00);
    base = n_rd + n_wr + n_busy;
    reg_write(3'd6, 8'h01);
    check("len0 req", bus.dma_req, 0);
    peek(3'd6, d);
    check("len0 status", d, 8'h40);
    repeat (3) @(negedge clk);
    check("len0 no bus", n_rd + n_wr + n_busy - base, 0);

    // Grant withdrawn for 3 clocks during the first write cycle.
    prog_regs(16'h5000, 16'h6000, 16'h0002, 8'h00);
    model_apply(16'h5000, 16'h6000, 2, 1'b0, 8'h00);
    base = n_rd + n_wr;
    reg_write(3'd6, 8'h01);
    k = 0;
    while (!(bus.mem_cs && !bus.mem_rw) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stall first wr", bus.mem_cs & ~bus.mem_rw, 1);
    gnt_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall cs%0d", i), bus.mem_cs, 0);
      check($sformatf("stall ad%0d", i), bus.mem_ad, 16'h6000);
      @(negedge clk);
    end
    gnt_force = 1'b1;
    reg_write(3'd0, 8'h55);
    wait_idle("stall", 50);
    check("stall cycles", n_rd + n_wr - base, 4);
    check_regs("stall", 16'h5002, 16'h6002, 16'h0000, 8'h40);
    mem_compare("stall");

    // Abort after three completed cycles; source wraps past 0xFFFF.
    prog_regs(16'hFFFF, 16'h4000, 16'h0005, 8'h00);
    base = n_rd + n_wr;
    reg_write(3'd6, 8'h01);
    k = 0;
    while ((n_rd + n_wr - base) < 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort 3 cycles", n_rd + n_wr - base, 3);
    reg_write(3'd6, 8'h04);
    check("abort req", bus.dma_req, 0);
    model_apply(16'hFFFF, 16'h4000, 2, 1'b0, 8'h00);
    check("abort cycles", n_rd + n_wr - base, 4);
    check_regs("abort", 16'h0001, 16'h4002, 16'h0003, 8'h20);
    mem_compare("abort");

`ifdef DMA_IRQ_EN
    prog_regs(16'h7000, 16'h7100, 16'h0001, 8'h00);
    model_apply(16'h7000, 16'h7100, 1, 1'b0, 8'h00);
    reg_write(3'd6, 8'h81);
    wait_idle("irq", 20);
    check("irq set", irq, 1);
    reg_read(3'd6, d);
    check("irq status", d, 8'h40);
    check("irq cleared", irq, 0);
    peek(3'd6, d);
    check("irq done cleared", d, 8'h00);
    mem_compare("irq");
`endif

    for (int t = 0; t < 20; t++) begin
      run_xfer($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom), $urandom_range(1, 12),
               1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a transfer drops the bus immediately.
    prog_regs(16'h8000, 16'h9000, 16'h0040, 8'h00);
    reg_write(3'd6, 8'h01);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst req", bus.dma_req, 0);
    check("async rst cs", bus.mem_cs, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
